// File: rtl/fetch_pkg.sv
// fetch_pkg: shared instruction-fetch types and defaults.
//   FETCH_RESET_PC : default first fetch address after reset
//   fetch_entry_t  : one buffered fetch result {fault, pc, instr}
package fetch_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: shift-register FIFO of fetch_entry_t; entry 0 is always the head register.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : enqueue an entry
//   i_pop          : dequeue the head (ignored when empty)
//   i_clear        : synchronous flush, wins over push
//   o_head         : head entry, straight from a register
//   o_valid        : FIFO not empty
//   o_count        : number of buffered entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  fetch_entry_t                 i_din,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output fetch_entry_t                 o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_idx;
    logic          pop_ok, push_ok;

    always_comb begin
        pop_ok  = i_pop && count_q != '0;
        // a full FIFO only accepts a push when the head leaves in the same cycle
        push_ok = i_push && (count_q != CW'(DEPTH) || pop_ok);
        wr_idx  = AW'(count_q - CW'(pop_ok));
        mem_d   = mem_q;
        if (pop_ok)
            for (int i = 0; i < DEPTH - 1; i++)
                mem_d[i] = mem_q[i + 1];
        if (push_ok)
            mem_d[wr_idx] = i_din;
        count_d = i_clear ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '{fault: 1'b0, pc: RESET_PC, instr: 32'h0};
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign o_head  = mem_q[0];
    assign o_valid = count_q != '0;
    assign o_count = count_q;

endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage; owns the PC, issues credit-limited word reads and
// buffers responses for decode, dropping wrong-path responses after a redirect.
//   i_clk, i_rst_n                      : clock, asynchronous active-low reset
//   o_imem_req_valid/addr, i_imem_req_ready : read request channel
//   i_imem_rsp_valid/data/err           : in-order response channel, never stalled
//   o_valid/o_instr/o_pc/o_fault, i_ready : decode handshake
//   i_redirect, i_redirect_pc           : flush and restart at a new target
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_fault,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d, redirect_pc;
    logic [CW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_count, outstanding_post;
    logic          req_fire, push, pop;
    fetch_entry_t  din, head;

    always_comb begin
        redirect_pc      = i_redirect_pc & ~32'h3;
        // credit: every accepted request must find a FIFO slot when it returns
        o_imem_req_valid = !i_redirect &&
                           ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
        o_imem_req_addr  = req_pc_q;
        req_fire         = o_imem_req_valid && i_imem_req_ready;
        pop              = o_valid && i_ready;
        push             = i_imem_rsp_valid && drop_cnt_q == '0 && !i_redirect;
        din              = '{fault: i_imem_rsp_err, pc: rsp_pc_q,
                             instr: i_imem_rsp_err ? 32'h0 : i_imem_rsp_data};
        outstanding_post = outstanding_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
        outstanding_d    = outstanding_post;
        req_pc_d         = i_redirect ? redirect_pc : req_fire ? req_pc_q + 32'd4 : req_pc_q;
        rsp_pc_d         = i_redirect ? redirect_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        // after a redirect everything still in flight belongs to the old path
        drop_cnt_d       = i_redirect ? outstanding_post :
                           (i_imem_rsp_valid && drop_cnt_q != '0) ? drop_cnt_q - 1'b1 : drop_cnt_q;
        o_instr          = head.instr;
        o_pc             = head.pc;
        o_fault          = head.fault;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_din   (din),
        .i_pop   (pop),
        .i_clear (i_redirect),
        .o_head  (head),
        .o_valid (o_valid),
        .o_count (fifo_count)
    );

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized and directed bench for fetch against a PC-stream reference model.
module tb_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = FETCH_RESET_PC;

    logic        clk = 1'b0, clk_en = 1'b1, rst_n = 1'b0;
    logic        req_valid, req_ready, rsp_valid, rsp_err, o_valid, o_fault, i_ready, redirect;
    logic [31:0] req_addr, rsp_data, o_instr, o_pc, redirect_pc;

    always #5 if (clk_en) clk = ~clk;

    fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (req_valid),
        .o_imem_req_addr  (req_addr),
        .i_imem_req_ready (req_ready),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_err   (rsp_err),
        .o_valid          (o_valid),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .o_fault          (o_fault),
        .i_ready          (i_ready),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc)
    );

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // memory contents and faults are pure functions of the address
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    bit          err_mask = 0;
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction
    function automatic bit mem_err(input logic [31:0] a);
        return a == err_addr || (err_mask && a[5:2] == 4'hB);
    endfunction

    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t       pend[$];
    int          lat = 1;
    int          cyc = 0, since_evt = 0, first_valid = 0, fires = 0, delivered = 0, drop_exp = 0;
    logic [31:0] exp_pc = RPC, req_exp = RPC, evt_pc = RPC, last_pc = 0, last_req_addr = 0;
    bit          prev_redir = 0, prev_stall = 0, saw_fault8 = 0, simul_armed = 0, simul_hit = 0;
    bit          last_valid = 0;
    logic [64:0] stall_snap;

    task automatic do_reset();
        rst_n = 1'b0;
        i_ready = 1'b0; req_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
        pend.delete();
        #1;
        check("reset_outputs", {o_valid, o_fault, o_pc, o_instr}, {1'b0, 1'b0, RPC, 32'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = RPC; req_exp = RPC; evt_pc = RPC;
        prev_redir = 0; prev_stall = 0; since_evt = 0; first_valid = 0;
    endtask

    // one clock cycle: entered and left at a falling edge
    task automatic step(input bit rdy, input bit mrdy, input bit redir, input logic [31:0] tgt);
        bit          rsp;
        int          out_before;
        logic [31:0] raddr;
        cyc++; since_evt++;
        out_before = pend.size();
        rsp = pend.size() > 0 && pend[0].due == cyc;
        if (simul_armed && rsp && o_valid && rdy) begin
            redir = 1'b1; tgt = 32'h203; simul_armed = 0; simul_hit = 1;
        end
        raddr = rsp ? pend[0].addr : 32'h0;
        if (rsp) void'(pend.pop_front());
        i_ready = rdy; req_ready = mrdy; redirect = redir; redirect_pc = tgt;
        rsp_valid = rsp;
        rsp_data  = rsp ? mem_data(raddr) : $urandom;
        rsp_err   = rsp ? mem_err(raddr) : 1'($urandom);
        #1;
        last_valid = o_valid;
        if (since_evt == 1 && !redir && out_before < DEPTH)
            check("first_req", {req_valid, req_addr}, {1'b1, evt_pc});
        if (prev_redir) begin
            check("valid_after_redirect", o_valid, 1'b0);
            check("drop_cnt_after_redirect", dut.drop_cnt_q, drop_exp);
        end
        if (prev_stall)
            check("stall_stable", {o_valid, o_fault, o_pc, o_instr}, {1'b1, stall_snap});
        if (redir) check("req_blocked_on_redirect", req_valid, 1'b0);
        if (o_valid && first_valid == 0) first_valid = since_evt;
        if (req_valid && mrdy) begin
            check("req_addr", req_addr, req_exp);
            pend.push_back('{cyc + lat, req_addr});
            last_req_addr = req_addr;
            req_exp += 32'd4;
            fires++;
        end
        check("outstanding_bound", pend.size() <= DEPTH, 1'b1);
        if (o_valid && rdy) begin
            check("deliver", {o_fault, o_pc, o_instr},
                  {mem_err(exp_pc), exp_pc, mem_err(exp_pc) ? 32'h0 : mem_data(exp_pc)});
            if (o_fault && o_pc == 32'h8) saw_fault8 = 1;
            last_pc = o_pc;
            exp_pc += 32'd4;
            delivered++;
        end
        check("invariant", dut.drop_cnt_q <= dut.outstanding_q && dut.outstanding_q <= DEPTH, 1'b1);
        prev_stall = o_valid && !rdy && !redir;
        stall_snap = {o_fault, o_pc, o_instr};
        prev_redir = redir;
        if (redir) begin
            exp_pc = tgt & ~32'h3; req_exp = exp_pc; evt_pc = exp_pc;
            drop_exp = pend.size(); since_evt = 0; first_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(negedge clk);

        // reset release, sequential fetch, bus error at 0x8
        lat = 1; err_addr = 32'h8; err_mask = 0;
        do_reset();
        fires = 0;
        repeat (8) step(1, 1, 0, 32'h0);
        check("consecutive_reqs", fires, 8);
        check("first_valid_cycle", first_valid, 3);
        repeat (4) step(1, 1, 0, 32'h0);
        check("fault_seen_pc8", saw_fault8, 1'b1);

        // backpressure from decode
        err_addr = 32'hFFFF_FFFF;
        do_reset();
        fires = 0;
        repeat (10) step(0, 1, 0, 32'h0);
        check("reqs_under_stall", fires, 4);
        check("stall_head", {o_valid, o_pc}, {1'b1, RPC});
        delivered = 0;
        repeat (6) step(1, 1, 0, 32'h0);
        check("drain_no_gap", delivered, 6);

        // redirect with responses in flight
        lat = 3;
        do_reset();
        for (int k = 0; k < 20 && pend.size() != 3; k++) step(1, 1, 0, 32'h0);
        check("three_outstanding", pend.size(), 3);
        step(1, 1, 1, 32'h100);
        delivered = 0;
        for (int k = 0; k < 30 && delivered == 0; k++) step(1, 1, 0, 32'h0);
        check("new_path_delivered", delivered > 0, 1'b1);
        check("first_after_redirect", last_pc, 32'h100);
        check("redirect_latency", first_valid, lat + 2);
        check("drop_cnt_zero", dut.drop_cnt_q, 0);

        // redirect, response and dequeue in one cycle
        lat = 1;
        do_reset();
        simul_armed = 1; simul_hit = 0;
        for (int k = 0; k < 20 && !simul_hit; k++) step(1, 1, 0, 32'h0);
        check("simul_hit", simul_hit, 1'b1);
        step(1, 1, 0, 32'h0);
        check("simul_req_addr", last_req_addr, 32'h200);
        check("simul_fifo_empty", last_valid, 1'b0);
        repeat (6) step(1, 1, 0, 32'h0);

        // asynchronous reset with the clock stopped
        lat = 2;
        do_reset();
        for (int k = 0; k < 10 && !o_valid; k++) step(1, 1, 0, 32'h0);
        check("valid_before_async", o_valid, 1'b1);
        clk_en = 1'b0;
        #7;
        rst_n = 1'b0;
        #1;
        check("async_valid_drop", o_valid, 1'b0);
        #12;
        clk_en = 1'b1;
        @(negedge clk);
        do_reset();
        delivered = 0;
        repeat (10) step(1, 1, 0, 32'h0);
        check("restart_delivers", delivered > 0, 1'b1);

        // randomized traffic
        err_mask = 1;
        for (int s = 0; s < 3; s++) begin
            lat = 1 + s;
            do_reset();
            delivered = 0;
            repeat (500)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0, $urandom);
            check("random_progress", delivered > 50, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
